// File: rtl/apb_bus_arbiter_if.sv
// apb_bus_arbiter_if: requester-side handshake and APB bus signals of the arbiter.
interface apb_bus_arbiter_if #(
    parameter int NREQ      = 2,
    parameter int DATAWIDTH = 32,
    parameter int ADDWIDTH  = 32
);
    logic [NREQ-1:0]           req;
    logic [NREQ-1:0]           req_write;
    logic [NREQ*ADDWIDTH-1:0]  req_addr;
    logic [NREQ*DATAWIDTH-1:0] req_wdata;
    logic [NREQ-1:0]           grant;
    logic [NREQ-1:0]           done;
    logic                      err;
    logic [DATAWIDTH-1:0]      rdata;
    logic [ADDWIDTH-1:0]       paddr;
    logic                      pwrite;
    logic [DATAWIDTH-1:0]      pwdata;
    logic                      psel;
    logic                      pen;
    logic                      pready;
    logic [DATAWIDTH-1:0]      prdata;

    modport master (
        input  req, req_write, req_addr, req_wdata, pready, prdata,
        output grant, done, err, rdata, paddr, pwrite, pwdata, psel, pen
    );

    modport slave (
        output req, req_write, req_addr, req_wdata, pready, prdata,
        input  grant, done, err, rdata, paddr, pwrite, pwdata, psel, pen
    );
endinterface

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: round-robin APB master sharing one slave among NREQ requesters,
// aborting any ACCESS phase that stalls TIMEOUT cycles (TIMEOUT=0 waits forever).
module apb_bus_arbiter #(
    parameter int NREQ      = 2,
    parameter int DATAWIDTH = 32,
    parameter int ADDWIDTH  = 32,
    parameter int TIMEOUT   = 16
) (
    input logic               clk,
    input logic               rst,
    apb_bus_arbiter_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2;
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d, gidx_q, gidx_d, pick, idx;
    logic                 found, tmo;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NREQ-1:0]      grant_q, grant_d, done_q, done_d;
    logic                 err_q, err_d, pwrite_q, pwrite_d, psel_q, psel_d, pen_q, pen_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d, pwdata_q, pwdata_d;
    logic [ADDWIDTH-1:0]  paddr_q, paddr_d;

    // First requesting index strictly after the last one served, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign tmo = (TIMEOUT > 0) && !bus.pready && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        done_d   = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        psel_d   = psel_q;
        pen_d    = pen_q;
        case (state_q)
            IDLE: begin
                grant_d = found ? NREQ'(1'b1) << pick : '0;
                psel_d  = found;
                pen_d   = 1'b0;
                if (found) begin
                    gidx_d   = pick;
                    paddr_d  = bus.req_addr[int'(pick) * ADDWIDTH +: ADDWIDTH];
                    pwdata_d = bus.req_wdata[int'(pick) * DATAWIDTH +: DATAWIDTH];
                    pwrite_d = bus.req_write[pick];
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                pen_d   = 1'b1;
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready || tmo) begin
                    done_d  = grant_q;
                    err_d   = tmo;
                    rdata_d = (bus.pready && !pwrite_q) ? bus.prdata : '0;
                    psel_d  = 1'b0;
                    pen_d   = 1'b0;
                    ptr_d   = gidx_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(NREQ - 1);
            gidx_q   <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;
    assign bus.paddr  = paddr_q;
    assign bus.pwrite = pwrite_q;
    assign bus.pwdata = pwdata_q;
    assign bus.psel   = psel_q;
    assign bus.pen    = pen_q;
endmodule

// File: tb/tb_apb_bus_arbiter.sv
// tb_apb_bus_arbiter: scenario tasks plus randomized transfers checked against
// a transfer-level round-robin / latency / timeout model.
module tb_apb_bus_arbiter;
    localparam int N = 3, DW = 32, AW = 32, TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0, bad = 0, last = N - 1;
    logic [AW-1:0] addr_a [N];
    logic [DW-1:0] data_a [N];
    logic          wr_a   [N];

    apb_bus_arbiter_if #(.NREQ(N), .DATAWIDTH(DW), .ADDWIDTH(AW)) b ();

    apb_bus_arbiter #(.NREQ(N), .DATAWIDTH(DW), .ADDWIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int rr(input logic [N-1:0] m, input int l);
        for (int k = 1; k <= N; k++) if (m[(l + k) % N]) return (l + k) % N;
        return 0;
    endfunction

    function automatic int exp_lat(input int ws);
        return 2 + (ws < TO ? ws : TO - 1);
    endfunction

    task automatic load(input int i);
        b.req_addr[i*AW +: AW]  = addr_a[i];
        b.req_wdata[i*DW +: DW] = data_a[i];
        b.req_write[i]          = wr_a[i];
    endtask

    // Drives one transfer and reports what the bus showed; no checking here.
    task automatic do_xfer(input logic [N-1:0] m, input int ws, input logic [DW-1:0] prd,
                           output logic [N-1:0] g, output logic [AW-1:0] a, output logic [DW-1:0] wd,
                           output logic wr, output int lat, output logic [N-1:0] dn, output logic er,
                           output logic [DW-1:0] rd, output logic ok, output logic gap);
        b.req = m; b.pready = 1'b0; b.prdata = prd;
        tick;
        g = b.grant; a = b.paddr; wd = b.pwdata; wr = b.pwrite;
        ok = b.psel && !b.pen && b.done == '0;
        lat = -1; dn = '0; er = 1'b0; rd = '0;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            b.pready    = (c >= 2) && (c - 2 >= ws);
            b.req_addr  = {$urandom, $urandom, $urandom};
            b.req_wdata = {$urandom, $urandom, $urandom};
            b.req_write = N'($urandom);
            b.req       = N'($urandom);
            tick;
            if (b.paddr !== a || b.pwdata !== wd || b.pwrite !== wr) ok = 1'b0;
            if (b.done !== '0) begin
                lat = c; dn = b.done; er = b.err; rd = b.rdata;
                if (b.psel || b.pen || b.grant !== g) ok = 1'b0;
            end else if (!b.psel || !b.pen || b.err || b.grant !== g) ok = 1'b0;
        end
        b.req = '0; b.pready = 1'b0;
        tick;
        gap = b.grant == '0 && !b.psel && b.done == '0 && !b.err;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick; tick;
        total++; if ({b.psel, b.pen, b.pwrite, b.err} !== 4'b0) begin bad++; $display("FAIL reset_ctl got=%b want=0000", {b.psel, b.pen, b.pwrite, b.err}); end
        total++; if (b.grant !== '0) begin bad++; $display("FAIL reset_grant got=%b want=0", b.grant); end
        total++; if (b.done !== '0) begin bad++; $display("FAIL reset_done got=%b want=0", b.done); end
        total++; if (b.paddr !== '0 || b.pwdata !== '0 || b.rdata !== '0) begin bad++; $display("FAIL reset_data got=%h/%h/%h want=0", b.paddr, b.pwdata, b.rdata); end
        rst = 1'b1; last = N - 1;
    endtask

    task automatic test_single_write;
        logic [N-1:0] g, dn; logic [AW-1:0] a; logic [DW-1:0] wd, rd; logic wr, er, ok, gap; int lat;
        addr_a[0] = 32'h4; data_a[0] = 32'hDEADBEEF; wr_a[0] = 1'b1; load(0);
        do_xfer(3'b001, 0, 32'h0, g, a, wd, wr, lat, dn, er, rd, ok, gap);
        total++; if (g !== 3'b001) begin bad++; $display("FAIL wr_grant got=%b want=001", g); end
        total++; if (a !== 32'h4 || wd !== 32'hDEADBEEF || wr !== 1'b1) begin bad++; $display("FAIL wr_bus got=%h/%h/%b want=4/deadbeef/1", a, wd, wr); end
        total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d want=2", lat); end
        total++; if (dn !== 3'b001 || er !== 1'b0) begin bad++; $display("FAIL wr_done got=%b/%b want=001/0", dn, er); end
        total++; if (!ok || !gap) begin bad++; $display("FAIL wr_stable got=%b/%b want=1/1", ok, gap); end
        last = 0;
    endtask

    task automatic test_single_read;
        logic [N-1:0] g, dn; logic [AW-1:0] a; logic [DW-1:0] wd, rd; logic wr, er, ok, gap; int lat;
        addr_a[1] = 32'h8; data_a[1] = 32'h0; wr_a[1] = 1'b0; load(1);
        do_xfer(3'b010, 0, 32'h12345678, g, a, wd, wr, lat, dn, er, rd, ok, gap);
        total++; if (g !== 3'b010 || a !== 32'h8 || wr !== 1'b0) begin bad++; $display("FAIL rd_setup got=%b/%h/%b want=010/8/0", g, a, wr); end
        total++; if (lat !== 2 || dn !== 3'b010) begin bad++; $display("FAIL rd_done got=%0d/%b want=2/010", lat, dn); end
        total++; if (rd !== 32'h12345678 || er !== 1'b0) begin bad++; $display("FAIL rd_data got=%h/%b want=12345678/0", rd, er); end
        last = 1;
    endtask

    task automatic test_wait_states;
        logic [N-1:0] g, dn; logic [AW-1:0] a; logic [DW-1:0] wd, rd; logic wr, er, ok, gap; int lat;
        addr_a[0] = 32'h100; data_a[0] = 32'hCAFE0001; wr_a[0] = 1'b1; load(0);
        do_xfer(3'b001, 3, 32'h0, g, a, wd, wr, lat, dn, er, rd, ok, gap);
        total++; if (lat !== 5) begin bad++; $display("FAIL wait_latency got=%0d want=5", lat); end
        total++; if (dn !== 3'b001 || er !== 1'b0) begin bad++; $display("FAIL wait_done got=%b/%b want=001/0", dn, er); end
        total++; if (!ok || a !== 32'h100 || wd !== 32'hCAFE0001) begin bad++; $display("FAIL wait_stable got=%b/%h/%h want=1/100/cafe0001", ok, a, wd); end
        last = 0;
    endtask

    task automatic test_timeout;
        logic [N-1:0] g, dn, ge; logic [AW-1:0] a; logic [DW-1:0] wd, rd; logic wr, er, ok, gap; int lat, w;
        for (int i = 0; i < 2; i++) begin addr_a[i] = 32'h200 + i; data_a[i] = $urandom; wr_a[i] = 1'b0; load(i); end
        w = rr(3'b011, last); ge = N'(1) << w;
        do_xfer(3'b011, 9, 32'hA5A50001, g, a, wd, wr, lat, dn, er, rd, ok, gap);
        total++; if (g !== ge) begin bad++; $display("FAIL to_grant got=%b want=%b", g, ge); end
        total++; if (lat !== exp_lat(9) || dn !== ge) begin bad++; $display("FAIL to_done got=%0d/%b want=%0d/%b", lat, dn, exp_lat(9), ge); end
        total++; if (er !== 1'b1 || rd !== '0) begin bad++; $display("FAIL to_err got=%b/%h want=1/0", er, rd); end
        last = w;
        for (int i = 0; i < 2; i++) load(i);
        w = rr(3'b011, last); ge = N'(1) << w;
        do_xfer(3'b011, 0, 32'h5A5A0002, g, a, wd, wr, lat, dn, er, rd, ok, gap);
        total++; if (g !== ge || dn !== ge || er !== 1'b0) begin bad++; $display("FAIL to_next got=%b/%b/%b want=%b/%b/0", g, dn, er, ge, ge); end
        last = w;
    endtask

    task automatic test_contention;
        int nd = 0, e; logic pp = 1'b0; int order [4];
        rst = 1'b0; tick; rst = 1'b1; last = N - 1;
        for (int i = 0; i < 2; i++) begin addr_a[i] = $urandom; data_a[i] = $urandom; wr_a[i] = 1'b1; load(i); end
        b.req = 3'b011; b.pready = 1'b1;
        for (int c = 0; c < 30 && nd < 4; c++) begin
            tick;
            e = rr(3'b011, last);
            if (b.psel && !b.pen) begin
                total++; if (b.grant !== N'(1) << e || pp) begin bad++; $display("FAIL cont_setup got=%b/prev_psel=%b want=%b/0", b.grant, pp, N'(1) << e); end
                total++; if (b.paddr !== addr_a[e]) begin bad++; $display("FAIL cont_addr got=%h want=%h", b.paddr, addr_a[e]); end
            end
            if (b.done !== '0) begin
                total++; if (b.done !== N'(1) << e) begin bad++; $display("FAIL cont_done got=%b want=%b", b.done, N'(1) << e); end
                order[nd] = e; last = e; nd++;
                if (nd == 4) b.req = '0;
            end
            pp = b.psel;
        end
        total++; if (nd !== 4) begin bad++; $display("FAIL cont_count got=%0d want=4", nd); end
        total++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin bad++; $display("FAIL cont_order got=%0d%0d%0d%0d want=0101", order[0], order[1], order[2], order[3]); end
        b.pready = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 2; i++) begin addr_a[i] = 32'h300 + i; data_a[i] = $urandom; wr_a[i] = 1'b0; load(i); end
        b.req = 3'b010; b.pready = 1'b0;
        tick; tick; tick;
        rst = 1'b0;
        tick;
        total++; if ({b.psel, b.pen} !== 2'b00 || b.grant !== '0 || b.done !== '0) begin bad++; $display("FAIL rmid_idle got=%b%b/%b/%b want=00/0/0", b.psel, b.pen, b.grant, b.done); end
        rst = 1'b1; last = N - 1; b.req = 3'b011;
        tick;
        total++; if (b.grant !== 3'b001 || !b.psel || b.done !== '0) begin bad++; $display("FAIL rmid_first got=%b/%b/%b want=001/1/0", b.grant, b.psel, b.done); end
        b.pready = 1'b1;
        tick; tick;
        total++; if (b.done !== 3'b001 || b.err) begin bad++; $display("FAIL rmid_done got=%b/%b want=001/0", b.done, b.err); end
        last = 0; b.req = '0; b.pready = 1'b0;
        tick;
    endtask

    task automatic test_random;
        logic [N-1:0] g, dn, m, ge; logic [AW-1:0] a; logic [DW-1:0] wd, rd, prd, erd; logic wr, er, ok, gap; int lat, ws, e;
        for (int it = 0; it < 40; it++) begin
            m = N'($urandom_range(1, 7));
            for (int i = 0; i < N; i++) begin addr_a[i] = $urandom; data_a[i] = $urandom; wr_a[i] = 1'($urandom); load(i); end
            ws = $urandom_range(0, 6); prd = $urandom;
            e = rr(m, last); ge = N'(1) << e;
            erd = (ws >= TO || wr_a[e]) ? '0 : prd;
            do_xfer(m, ws, prd, g, a, wd, wr, lat, dn, er, rd, ok, gap);
            total++; if (g !== ge) begin bad++; $display("FAIL rnd%0d grant got=%b want=%b", it, g, ge); end
            total++; if (a !== addr_a[e] || wd !== data_a[e] || wr !== wr_a[e]) begin bad++; $display("FAIL rnd%0d bus got=%h/%h/%b want=%h/%h/%b", it, a, wd, wr, addr_a[e], data_a[e], wr_a[e]); end
            total++; if (lat !== exp_lat(ws) || dn !== ge) begin bad++; $display("FAIL rnd%0d done got=%0d/%b want=%0d/%b", it, lat, dn, exp_lat(ws), ge); end
            total++; if (er !== (ws >= TO) || rd !== erd) begin bad++; $display("FAIL rnd%0d result got=%b/%h want=%b/%h", it, er, rd, ws >= TO, erd); end
            total++; if (!ok || !gap) begin bad++; $display("FAIL rnd%0d stable got=%b/%b want=1/1", it, ok, gap); end
            last = e;
        end
    endtask

    initial begin
        b.req = '0; b.req_write = '0; b.req_addr = '0; b.req_wdata = '0; b.pready = 1'b0; b.prdata = '0;
        test_reset;
        test_single_write;
        test_single_read;
        test_wait_states;
        test_timeout;
        test_contention;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
